// File: rtl/shift_add_multiplier.sv
// Sequential unsigned radix-2 shift-and-add multiplier.
// Each EXEC cycle conditionally adds the multiplicand to the upper half of the
// product register through a chain of 4-bit carry-look-ahead cells, then shifts
// the {carry, accumulator, multiplier} pair right by one bit. After WIDTH
// iterations the exact 2*WIDTH-bit product is held until op_clear.
module shift_add_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 op_start,
  input  logic                 op_clear,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   result,
  output logic                 op_done,
  output logic                 busy
);

  localparam int CELLS = WIDTH / 4;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // 4-bit carry-look-ahead cell: returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

  logic [1:0]           state_r;
  logic [CNT_W-1:0]     count_r;
  logic [WIDTH-1:0]     mcand_r;
  logic [2*WIDTH-1:0]   result_r;
  logic                 op_done_r;
  logic                 busy_r;

  logic [WIDTH-1:0]     addend_s;
  logic [WIDTH-1:0]     sum_s;
  logic [CELLS:0]       chain_c_s;
  logic                 last_iter_s;

  // Select the addend: multiplicand when the current multiplier LSB is set, else zero.
  always_comb begin
    addend_s = {WIDTH{1'b0}};
    if (result_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = {WIDTH{1'b0}};
    end
  end

  // Ripple the carry through the chain of cla4 cells over the upper product half.
  always_comb begin
    sum_s        = {WIDTH{1'b0}};
    chain_c_s    = {(CELLS+1){1'b0}};
    chain_c_s[0] = 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      {chain_c_s[i+1], sum_s[4*i +: 4]} =
        cla4(result_r[WIDTH + 4*i +: 4], addend_s[4*i +: 4], chain_c_s[i]);
    end
  end

  assign last_iter_s = (count_r == CNT_W'(WIDTH - 1));

  // Control FSM, iteration counter and product/operand registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      count_r   <= {CNT_W{1'b0}};
      mcand_r   <= {WIDTH{1'b0}};
      result_r  <= {(2*WIDTH){1'b0}};
      op_done_r <= 1'b0;
      busy_r    <= 1'b0;
    end else if (op_clear) begin
      state_r   <= ST_IDLE;
      count_r   <= {CNT_W{1'b0}};
      result_r  <= {(2*WIDTH){1'b0}};
      op_done_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (op_start) begin
            mcand_r  <= multiplicand;
            result_r <= {{WIDTH{1'b0}}, multiplier};
            count_r  <= {CNT_W{1'b0}};
            state_r  <= ST_EXEC;
            busy_r   <= 1'b1;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          // The top carry becomes the new MSB, so no product bit is lost.
          result_r <= {chain_c_s[CELLS], sum_s, result_r[WIDTH-1:1]};
          count_r  <= count_r + CNT_W'(1);
          if (last_iter_s) begin
            state_r   <= ST_DONE;
            busy_r    <= 1'b0;
            op_done_r <= 1'b1;
          end else begin
            state_r   <= ST_EXEC;
          end
        end
        ST_DONE: begin
          state_r <= ST_DONE;
        end
        default: begin
          state_r   <= ST_IDLE;
          count_r   <= {CNT_W{1'b0}};
          result_r  <= {(2*WIDTH){1'b0}};
          op_done_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign result  = result_r;
  assign op_done = op_done_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (WIDTH=32 and WIDTH=8 instances).
module tb_shift_add_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        op_start;
  logic        op_clear;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [63:0] result;
  logic        op_done;
  logic        busy;

  logic        op_start8;
  logic        op_clear8;
  logic [7:0]  mcand8;
  logic [7:0]  mplier8;
  logic [15:0] result8;
  logic        op_done8;
  logic        busy8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [6];

  shift_add_multiplier #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .op_start(op_start), .op_clear(op_clear),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .result(result), .op_done(op_done), .busy(busy)
  );

  shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .op_start(op_start8), .op_clear(op_clear8),
    .multiplicand(mcand8), .multiplier(mplier8),
    .result(result8), .op_done(op_done8), .busy(busy8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents operands with a one-cycle op_start pulse; returns after edge 0.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    op_start     = 1'b1;
    @(negedge clk);
    op_start     = 1'b0;
  endtask

  // Counts edges until op_done, noting whether busy stayed high meanwhile.
  task automatic wait_done(output int cyc, output bit busy_ok);
    cyc     = 0;
    busy_ok = 1'b1;
    while (!op_done && cyc < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic clear_op();
    @(negedge clk);
    op_clear = 1'b1;
    @(negedge clk);
    op_clear = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    int cyc;
    bit busy_ok;
    start_op(a, b);
    wait_done(cyc, busy_ok);
    check({name, "_latency"}, 64'(cyc), 64'd32);
    check({name, "_busy_exec"}, 64'(busy_ok), 64'd1);
    check({name, "_result"}, result, exp);
    check({name, "_busy_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int cyc;
    bit busy_ok;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
    vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'd0,          32'h1234_5678,  64'h0};
    vecs[3] = '{32'd10,         32'd10,         64'd100};
    vecs[4] = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000};
    vecs[5] = '{32'd1,          32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF};

    reset_n = 1'b0; op_start = 1'b0; op_clear = 1'b0;
    multiplicand = 32'd0; multiplier = 32'd0;
    op_start8 = 1'b0; op_clear8 = 1'b0; mcand8 = 8'd0; mplier8 = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_result", result, 64'd0);
    check("reset_done", 64'(op_done), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Table-driven directed vectors.
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);
      if (i == 0) begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          check("hold_result", result, 64'h0000_0000_0000_000F);
          check("hold_done", 64'(op_done), 64'd1);
        end
      end
      clear_op();
      check("clear_result", result, 64'd0);
      check("clear_done", 64'(op_done), 64'd0);
    end

    // op_start and operand changes during EXEC are ignored.
    start_op(32'd7, 32'd9);
    repeat (9) @(negedge clk);
    multiplicand = 32'd2; multiplier = 32'd2; op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    wait_done(cyc, busy_ok);
    check("midexec_latency", 64'(10 + cyc), 64'd32);
    check("midexec_result", result, 64'd63);
    start_op(32'd2, 32'd2);
    repeat (2) @(negedge clk);
    check("done_start_result", result, 64'd63);
    check("done_start_done", 64'(op_done), 64'd1);
    check("done_start_busy", 64'(busy), 64'd0);
    clear_op();
    check("clear2_result", result, 64'd0);
    check("clear2_done", 64'(op_done), 64'd0);
    run_op("after_clear", 32'd2, 32'd2, 64'd4);
    clear_op();

    // op_clear together with op_start mid-EXEC wins and starts nothing.
    start_op(32'd12345, 32'd678);
    repeat (14) @(negedge clk);
    op_clear = 1'b1; op_start = 1'b1;
    @(negedge clk);
    op_clear = 1'b0; op_start = 1'b0;
    check("clrstart_result", result, 64'd0);
    check("clrstart_busy", 64'(busy), 64'd0);
    check("clrstart_done", 64'(op_done), 64'd0);
    repeat (5) @(negedge clk);
    check("clrstart_idle_busy", 64'(busy), 64'd0);
    check("clrstart_idle_result", result, 64'd0);

    // Asynchronous reset between edges mid-EXEC.
    start_op(32'd7, 32'd9);
    repeat (20) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("areset_result", result, 64'd0);
    check("areset_busy", 64'(busy), 64'd0);
    check("areset_done", 64'(op_done), 64'd0);
    #1 reset_n = 1'b1;
    run_op("post_reset", 32'd10, 32'd10, 64'd100);
    clear_op();

    // Randomized pairs against the arithmetic reference A*B.
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFF;
      if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
      if ($urandom_range(0, 15) == 0) ra = 32'd0;
      start_op(ra, rb);
      wait_done(cyc, busy_ok);
      checks++;
      if (result !== 64'(ra) * 64'(rb) || cyc != 32) begin
        errors++;
        $display("FAIL rand%0d: A=%h B=%h got 0x%h in %0d cycles expected 0x%h in 32",
                 n, ra, rb, result, cyc, 64'(ra) * 64'(rb));
      end
      clear_op();
    end

    // WIDTH=8 instance: FF*FF with 8-cycle latency.
    @(negedge clk);
    mcand8 = 8'hFF; mplier8 = 8'hFF; op_start8 = 1'b1;
    @(negedge clk);
    op_start8 = 1'b0;
    cyc = 0;
    while (!op_done8 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("w8_latency", 64'(cyc), 64'd8);
    check("w8_result", 64'(result8), 64'h0000_0000_0000_FE01);
    check("w8_busy", 64'(busy8), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
